multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-style control FSM
// Moore outputs from the state; only FETCH write enables depend on mem_ready.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_EN     = 1,
  parameter int unsigned IMM_EN          = 1,
  parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXEC_I = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic       mem_rdy;
  logic       is_imm;
  logic [2:0] imm_alu_op;

  assign mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign is_imm  = (IMM_EN != 0) &&
                   (opCode == 6'h08 || opCode == 6'h0C || opCode == 6'h0D);

  always_comb begin
    imm_alu_op = 3'b000;
    case (opCode)
      6'h0C:   imm_alu_op = 3'b011;
      6'h0D:   imm_alu_op = 3'b100;
      default: imm_alu_op = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (opCode == 6'h00)                          state_d = S_EXEC_R;
        else if (opCode == 6'h23 || opCode == 6'h2B)  state_d = S_MEMADR;
        else if (opCode == 6'h04 || opCode == 6'h05)  state_d = S_BRANCH;
        else if (opCode == 6'h02)                     state_d = S_JUMP;
        else if (is_imm)                              state_d = S_EXEC_I;
        else if (TRAP_ON_ILLEGAL != 0)                state_d = S_TRAP;
        else                                          state_d = S_FETCH;
      end
      S_MEMADR: state_d = (opCode == 6'h2B) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_TRAP:   state_d = S_TRAP;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (opCode == 6'h05);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      // IWB keeps the ALU driving the result that is being written back.
      S_EXEC_I, S_IWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        ALUOp    = imm_alu_op;
        RegWrite = (state_q == S_IWB);
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign illegal = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized instruction-level bench for multicycle_ctrl
// dut0 defaults, dut1 IMM_EN=0/TRAP_ON_ILLEGAL=0, dut2 MEM_WAIT_EN=0.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst [3];
  logic [5:0]  opc [3];
  logic        mrd [3];
  logic [17:0] ctl [3];
  logic [3:0]  st  [3];
  logic        ill [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl #(
      .MEM_WAIT_EN    ((g == 2) ? 0 : 1),
      .IMM_EN         ((g == 1) ? 0 : 1),
      .TRAP_ON_ILLEGAL((g == 1) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .opCode     (opc[g]),
      .mem_ready  (mrd[g]),
      .PCWrite    (ctl[g][17]),
      .PCWriteCond(ctl[g][16]),
      .BranchNE   (ctl[g][15]),
      .IorD       (ctl[g][14]),
      .MemRead    (ctl[g][13]),
      .MemWrite   (ctl[g][12]),
      .MemtoReg   (ctl[g][11]),
      .IRWrite    (ctl[g][10]),
      .ALUSrcA    (ctl[g][9]),
      .ALUSrcB    (ctl[g][8:7]),
      .ALUOp      (ctl[g][6:4]),
      .PCSource   (ctl[g][3:2]),
      .RegWrite   (ctl[g][1]),
      .RegDst     (ctl[g][0]),
      .state      (st[g]),
      .illegal    (ill[g])
    );
  end

  function automatic bit mw_en(input int i);  return i != 2; endfunction
  function automatic bit imm_en(input int i); return i != 1; endfunction
  function automatic bit trap_en(input int i); return i != 1; endfunction

  // Returns {illegal, ctl} as the control table says for a state.
  function automatic logic [18:0] exp_out(input int s, input logic [5:0] op, input logic mr);
    logic pcw, pcwc, bne, iord, mrd_o, mwr, m2r, irw, srca, rw, rdst, il;
    logic [1:0] srcb, pcs;
    logic [2:0] aop, iop;
    {pcw, pcwc, bne, iord, mrd_o, mwr, m2r, irw, srca, rw, rdst, il} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 3'b000;
    iop = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b100 : 3'b000;
    case (s)
      0:  begin mrd_o = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd_o = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 3'b010; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; bne = (op == 6'h05); end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; aop = iop; end
      11: begin srca = 1; srcb = 2'b10; aop = iop; rw = 1; end
      12: il = 1;
      default: ;
    endcase
    return {il, pcw, pcwc, bne, iord, mrd_o, mwr, m2r, irw, srca, srcb, aop, pcs, rw, rdst};
  endfunction

  // One clock cycle: drive inputs on the falling edge, check the state entered at the last rise.
  task automatic step(input int i, input int s, input logic [5:0] op, input logic mr, input string nm);
    logic [18:0] e;
    @(negedge clk);
    rst[i] = 1'b0; opc[i] = op; mrd[i] = mr;
    #1;
    e = exp_out(s, op, mw_en(i) ? mr : 1'b1);
    n_chk++;
    if (st[i] !== 4'(s)) begin
      n_fail++;
      $display("FAIL %s dut%0d state: got %0d required %0d", nm, i, st[i], s);
    end
    n_chk++;
    if ({ill[i], ctl[i]} !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d outputs(state %0d): got %h required %h", nm, i, s, {ill[i], ctl[i]}, e);
    end
  endtask

  task automatic do_reset(input int i);
    @(negedge clk);
    rst[i] = 1'b1; mrd[i] = 1'($urandom); opc[i] = 6'($urandom);
  endtask

  // Walks one instruction through the sequence of states its class visits.
  task automatic run_instr(input int i, input logic [5:0] op, input int fw, input int mw, input string nm);
    int path[$];
    int w;
    logic [5:0] ox;
    path = '{0, 1};
    case (op)
      6'h00: path = {path, 6, 7};
      6'h23: path = {path, 2, 3, 4};
      6'h2B: path = {path, 2, 5};
      6'h04, 6'h05: path.push_back(8);
      6'h02: path.push_back(9);
      6'h08, 6'h0C, 6'h0D:
        if (imm_en(i)) path = {path, 10, 11};
        else if (trap_en(i)) path.push_back(12);
      default: if (trap_en(i)) path.push_back(12);
    endcase
    foreach (path[k]) begin
      ox = (path[k] == 0) ? 6'($urandom) : op;
      if ((path[k] == 0 || path[k] == 3 || path[k] == 5) && mw_en(i)) begin
        w = (path[k] == 0) ? fw : mw;
        if (w < 0) w = $urandom_range(0, 2);
        repeat (w) step(i, path[k], ox, 1'b0, nm);
        step(i, path[k], ox, 1'b1, nm);
      end else begin
        step(i, path[k], ox, 1'($urandom), nm);
      end
    end
    if (path[path.size()-1] == 12) begin
      repeat ($urandom_range(1, 3)) step(i, 12, 6'($urandom), 1'($urandom), nm);
      do_reset(i);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      do_reset(i);
      step(i, 0, 6'($urandom), 1'b0, "reset_mr0");
      do_reset(i);
      step(i, 0, 6'($urandom), 1'b1, "reset_mr1");
      do_reset(i);
    end
  endtask

  task automatic test_lw();
    do_reset(0);
    run_instr(0, 6'h23, 0, 0, "lw_ready");
    step(0, 0, 6'h00, 1'b0, "lw_done");
  endtask

  task automatic test_lw_wait();
    do_reset(0);
    run_instr(0, 6'h23, 0, 3, "lw_wait");
    step(0, 0, 6'h00, 1'b0, "lw_wait_done");
  endtask

  task automatic test_branch();
    do_reset(0);
    run_instr(0, 6'h05, 0, 0, "bne");
    run_instr(0, 6'h04, 0, 0, "beq");
    run_instr(0, 6'h02, 1, 0, "jump");
    step(0, 0, 6'h00, 1'b0, "branch_done");
  endtask

  task automatic test_imm();
    do_reset(0);
    run_instr(0, 6'h0D, 0, 0, "ori_legal");
    step(0, 0, 6'h00, 1'b0, "ori_done");
    do_reset(1);
    run_instr(1, 6'h0D, 0, 0, "ori_nop");
    step(1, 0, 6'h00, 1'b0, "ori_nop_done");
  endtask

  task automatic test_trap();
    do_reset(0);
    step(0, 0, 6'h3F, 1'b1, "trap");
    step(0, 1, 6'h3F, 1'b1, "trap");
    repeat (12) step(0, 12, 6'($urandom), 1'($urandom), "trap_hold");
    do_reset(0);
    step(0, 0, 6'h00, 1'b0, "trap_reset");
  endtask

  task automatic test_reset_memwr();
    do_reset(0);
    step(0, 0, 6'h11, 1'b1, "sw_rst");
    step(0, 1, 6'h2B, 1'b0, "sw_rst");
    step(0, 2, 6'h2B, 1'b0, "sw_rst");
    step(0, 5, 6'h2B, 1'b0, "sw_rst");
    step(0, 5, 6'h2B, 1'b0, "sw_rst");
    @(negedge clk);
    rst[0] = 1'b1; mrd[0] = 1'b0;
    step(0, 0, 6'h2B, 1'b0, "sw_rst_after");
    n_chk++;
    if (ctl[0][12] !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_rst_memwrite: got %b required 0", ctl[0][12]);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h3F};
    logic [5:0] op;
    for (int i = 0; i < 3; i++) begin
      do_reset(i);
      for (int n = 0; n < 40; n++) begin
        op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
        run_instr(i, op, -1, -1, "random");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; opc[i] = 6'h00; mrd[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_lw();
    test_lw_wait();
    test_branch();
    test_imm();
    test_trap();
    test_reset_memwr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
